psec6_trigger_gen: RTL

PSEC6_TRIGGER_GEN -- requirements
Module: psec6_trigger_gen

---
 rtl/psec6_trigger_gen.sv | 129 ++++++++++++
 1 files changed

// File: rtl/psec6_trigger_gen.sv
// Self-trigger generator: detects rising edges on eight discriminator channels,
// qualifies them by mode, then fires a held trigger level after a programmable delay.
module psec6_trigger_gen (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  disc_in,
    input  logic [7:0]  disc_polarity,
    input  logic [7:0]  trigger_channel_mask,
    input  logic [1:0]  mode,
    input  logic [5:0]  trigger_delay,
    input  logic        inst_start,
    input  logic        inst_rst,
    output logic        trigger_out,
    output logic        armed,
    output logic [7:0]  trigger_source,
    output logic [15:0] trigger_count,
    output logic [1:0]  state_dbg
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DELAY = 2'd2,
        HOLD  = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [7:0]  prev_eff_q, prev_eff_d;
    logic [7:0]  trigger_source_q, trigger_source_d;
    logic [15:0] trigger_count_q, trigger_count_d;
    logic        trigger_out_q, trigger_out_d;
    logic        armed_q, armed_d;

    logic [7:0]  eff;
    logic [7:0]  hit;
    logic [3:0]  hit_pop;
    logic        cond;

    assign eff = ~(disc_in ^ disc_polarity);
    assign hit = eff & ~prev_eff_q & trigger_channel_mask;

    always_comb begin
        hit_pop = 4'd0;
        for (int i = 0; i < 8; i++) begin
            hit_pop = hit_pop + {3'd0, hit[i]};
        end
    end

    // Mode 3 requires every enabled channel to have a fresh edge in the same cycle.
    always_comb begin
        cond = 1'b0;
        case (mode)
            2'd0:    cond = 1'b0;
            2'd1:    cond = |hit;
            2'd2:    cond = (hit_pop >= 4'd2);
            default: cond = (|trigger_channel_mask) && (&(hit | ~trigger_channel_mask));
        endcase
    end

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q;
        trigger_source_d = trigger_source_q;
        trigger_count_d  = trigger_count_q;
        prev_eff_d       = eff;

        case (state_q)
            IDLE: begin
                if (inst_start) state_d = ARMED;
            end
            ARMED: begin
                if (cond) begin
                    trigger_source_d = hit;
                    cnt_d            = trigger_delay;
                    state_d          = (trigger_delay == 6'd0) ? HOLD : DELAY;
                end
            end
            DELAY: begin
                cnt_d = cnt_q - 6'd1;
                if (cnt_q <= 6'd1) state_d = HOLD;
            end
            default: begin
                if (inst_start) state_d = ARMED;
            end
        endcase

        // The clear pulse overrides any transition chosen above, including a same-cycle start.
        if (inst_rst) begin
            state_d          = IDLE;
            cnt_d            = 6'd0;
            trigger_source_d = 8'h00;
        end

        if (state_d == HOLD && state_q != HOLD && trigger_count_q != 16'hFFFF) begin
            trigger_count_d = trigger_count_q + 16'd1;
        end

        trigger_out_d = (state_d == HOLD);
        armed_d       = (state_d == ARMED);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= IDLE;
            cnt_q            <= 6'd0;
            prev_eff_q       <= 8'hFF;
            trigger_source_q <= 8'h00;
            trigger_count_q  <= 16'h0000;
            trigger_out_q    <= 1'b0;
            armed_q          <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            prev_eff_q       <= prev_eff_d;
            trigger_source_q <= trigger_source_d;
            trigger_count_q  <= trigger_count_d;
            trigger_out_q    <= trigger_out_d;
            armed_q          <= armed_d;
        end
    end

    assign trigger_out    = trigger_out_q;
    assign armed          = armed_q;
    assign trigger_source = trigger_source_q;
    assign trigger_count  = trigger_count_q;
    assign state_dbg      = state_q;

endmodule
